// File: rtl/mac_pkg.sv
// mac_pkg
// Shared constants and types for the MAC array back end.
//   BW      : operand width of the upstream MAC.
//   BW_PSUM : width of one signed partial sum leaving the MAC array.
//   BW_ACC  : accumulator width. It holds 16 worst-case partial sums.
//   LEN_BW  : width of the beats-per-output count.
//   acc_state_t : state encoding of the partial-sum accumulator.
package mac_pkg;

  localparam int BW      = 8;
  localparam int BW_PSUM = 2*BW + 4;
  localparam int BW_ACC  = BW_PSUM + 4;
  localparam int LEN_BW  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } acc_state_t;

endpackage

// File: rtl/mac_psum_acc_if.sv
// mac_psum_acc_if
// Bundles the two valid/ready channels of the partial-sum accumulator.
//   Input side  : len, psum_in, in_valid (towards the accumulator), in_ready (back).
//   Output side : out_data, out_valid (from the accumulator), out_ready (back).
// Modports:
//   slave  : the accumulator itself.
//   master : whatever drives the partial sums and drains the results.
interface mac_psum_acc_if;
  import mac_pkg::*;

  logic        [LEN_BW-1:0]  len;
  logic signed [BW_PSUM-1:0] psum_in;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BW_ACC-1:0]  out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  len,
    input  psum_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output len,
    output psum_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/mac_psum_acc.sv
// mac_psum_acc
// Downstream stage of the 8-lane signed MAC array. It sums N consecutive
// signed partial sums into a 24-bit accumulator. N is 1..15; it is taken from
// len on the first beat, and a len of 0 counts as 1. The finished sum is
// presented on a valid/ready output. A new group may start in the same cycle
// the previous result is taken, so throughput is one result every N cycles.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clear   : synchronous flush. It drops any partial or pending result and
//             blocks input for that cycle.
//   busy    : high while a group is being accumulated or a result is pending
//   bus     : mac_psum_acc_if.slave (psum input channel + result output channel)
// Build option:
//   MAC_PSUM_ACC_RELU_EN : when defined, negative results are clamped to zero
//   as they are loaded into out_data. The accumulator itself is never clamped.
module mac_psum_acc
  import mac_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic          busy,
  mac_psum_acc_if.slave bus
);

  acc_state_t                state_q, state_d;
  logic signed [BW_ACC-1:0]  acc_q, acc_d;
  logic signed [BW_ACC-1:0]  out_data_q, out_data_d;
  logic        [LEN_BW-1:0]  cnt_q, cnt_d;
  logic        [LEN_BW-1:0]  n_lat_q, n_lat_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;

  logic signed [BW_ACC-1:0]  psum_ext;
  logic signed [BW_ACC-1:0]  acc_sum;
  logic        [LEN_BW-1:0]  len_eff;
  logic                      in_ready;
  logic                      in_fire;
  logic                      out_fire;
  logic                      take_first;
  logic                      take_next;

  function automatic logic signed [BW_ACC-1:0] sext_psum(
    input logic signed [BW_PSUM-1:0] p
  );
    return {{(BW_ACC-BW_PSUM){p[BW_PSUM-1]}}, p};
  endfunction

  // Value placed on out_data. With the ReLU build, negative sums read as zero.
  function automatic logic signed [BW_ACC-1:0] out_clamp(
    input logic signed [BW_ACC-1:0] v
  );
`ifdef MAC_PSUM_ACC_RELU_EN
    return v[BW_ACC-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign psum_ext = sext_psum(bus.psum_in);
  assign acc_sum  = acc_q + psum_ext;
  assign len_eff  = (bus.len == '0) ? LEN_BW'(1) : bus.len;

  // The input is open while collecting. While a result is pending, the input
  // is open only if that result leaves in the same cycle; this is the
  // back-to-back overlap path. clear always closes the input.
  always_comb begin
    in_ready = 1'b0;
    if (!clear) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        ACC:     in_ready = 1'b1;
        DONE:    in_ready = bus.out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign in_fire    = bus.in_valid & in_ready;
  assign out_fire   = out_valid_q & bus.out_ready;
  assign take_first = in_fire & ((state_q == IDLE) | (state_q == DONE));
  assign take_next  = in_fire & (state_q == ACC);

  // Next-state logic. A first beat loads the accumulator and latches N.
  // Any beat that completes a group also loads out_data, so out_data changes
  // only when a new result is presented.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_lat_d     = n_lat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end

      if (take_first) begin
        acc_d   = psum_ext;
        cnt_d   = LEN_BW'(1);
        n_lat_d = len_eff;
        if (len_eff == LEN_BW'(1)) begin
          state_d     = DONE;
          out_data_d  = out_clamp(psum_ext);
          out_valid_d = 1'b1;
        end else begin
          state_d = ACC;
        end
      end else if (take_next) begin
        acc_d = acc_sum;
        cnt_d = cnt_q + LEN_BW'(1);
        if ((cnt_q + LEN_BW'(1)) == n_lat_q) begin
          state_d     = DONE;
          out_data_d  = out_clamp(acc_sum);
          out_valid_d = 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers. All of them return to zero/IDLE on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_lat_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_lat_q     <= n_lat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mac_psum_acc.sv
// tb_mac_psum_acc
// Directed bench for mac_psum_acc. A group-level model of the accumulator
// (running sum, beats still needed, pending result) tracks every cycle. The
// outputs are compared against that model on each falling edge. A few
// hand-computed literals pin the model at key points.
module tb_mac_psum_acc;
  import mac_pkg::*;

`ifdef MAC_PSUM_ACC_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic busy;

  mac_psum_acc_if bus_if();

  mac_psum_acc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .busy    (busy),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checks_on = 1'b0;

  // Group-level model state
  bit          m_collecting;
  bit          m_have;
  longint      m_sum;
  int          m_need;
  logic [23:0] m_result;

  function automatic logic [23:0] toOut(input longint s);
    logic [23:0] v;
    v = s[23:0];
    if (RELU_ON && v[23]) v = 24'h0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%06h, expected 0x%06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_collecting = 1'b0;
    m_have       = 1'b0;
    m_sum        = 0;
    m_need       = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the rising edge,
  // and return 1 time unit after that edge.
  task automatic applyStimulus(input bit clr, input bit vld, input int ln, input int ps, input bit ordy);
    bit in_fire;
    bit out_fire;
    clear            = clr;
    bus_if.in_valid  = vld;
    bus_if.len       = ln[3:0];
    bus_if.psum_in   = ps[19:0];
    bus_if.out_ready = ordy;
    @(posedge clk);
    if (clr) begin
      modelReset();
    end else begin
      out_fire = m_have && ordy;
      in_fire  = vld && (!m_have || ordy);
      if (out_fire) m_have = 1'b0;
      if (in_fire) begin
        if (!m_collecting) begin
          m_sum        = ps;
          m_need       = (ln == 0) ? 1 : ln;
          m_collecting = 1'b1;
        end else begin
          m_sum += ps;
        end
        m_need--;
        if (m_need == 0) begin
          m_collecting = 1'b0;
          m_have       = 1'b1;
          m_result     = toOut(m_sum);
        end
      end
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checks_on) begin
      checkOutput("in_ready", 24'(bus_if.in_ready), 24'(!clear && (!m_have || bus_if.out_ready)));
      checkOutput("out_valid", 24'(bus_if.out_valid), 24'(m_have));
      checkOutput("busy", 24'(busy), 24'(m_collecting || m_have));
      if (m_have) checkOutput("out_data", bus_if.out_data, m_result);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n          = 1'b0;
    clear            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.len       = '0;
    bus_if.psum_in   = '0;
    bus_if.out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 24'(bus_if.in_ready), 24'h1);
    checkOutput("reset_out_valid", 24'(bus_if.out_valid), 24'h0);
    checkOutput("reset_out_data", bus_if.out_data, 24'h0);
    checkOutput("reset_busy", 24'(busy), 24'h0);
    reset_n   = 1'b1;
    checks_on = 1'b1;
    idleCycle();

    // Basic group of four; later len values must be ignored
    $display("[TB] basic len=4");
    applyStimulus(1'b0, 1'b1, 4, 100, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, -30, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, 7, 1'b1);
    checkOutput("basic_not_yet_valid", 24'(bus_if.out_valid), 24'h0);
    applyStimulus(1'b0, 1'b1, 1, -200, 1'b1);
    checkOutput("basic_valid", 24'(bus_if.out_valid), 24'h1);
    checkOutput("basic_data", bus_if.out_data, RELU_ON ? 24'h000000 : 24'hFFFF85);
    idleCycle();

    // Extremes: fifteen full-scale beats of each sign
    $display("[TB] extremes len=15");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 15, -524288, 1'b1);
    checkOutput("extreme_neg", bus_if.out_data, RELU_ON ? 24'h000000 : 24'h880000);
    idleCycle();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 15, 524287, 1'b1);
    checkOutput("extreme_pos", bus_if.out_data, 24'h77FFF1);
    idleCycle();

    // Back-pressure, then a result and a new first beat firing together
    $display("[TB] backpressure len=2");
    applyStimulus(1'b0, 1'b1, 2, 3, 1'b1);
    applyStimulus(1'b0, 1'b1, 2, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2, 9, 1'b0);
      checkOutput("bp_in_ready", 24'(bus_if.in_ready), 24'h0);
      checkOutput("bp_hold_data", bus_if.out_data, 24'd7);
    end
    applyStimulus(1'b0, 1'b1, 2, 9, 1'b1);
    checkOutput("overlap_valid_drop", 24'(bus_if.out_valid), 24'h0);
    checkOutput("overlap_busy", 24'(busy), 24'h1);
    applyStimulus(1'b0, 1'b1, 2, 1, 1'b1);
    checkOutput("overlap_data", bus_if.out_data, 24'd10);
    idleCycle();

    // in_valid gaps inside a group
    $display("[TB] gaps len=3");
    applyStimulus(1'b0, 1'b1, 3, 10, 1'b1);
    applyStimulus(1'b0, 1'b0, 3, 99, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 20, 1'b1);
    applyStimulus(1'b0, 1'b0, 3, 99, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 30, 1'b1);
    checkOutput("gap_data", bus_if.out_data, 24'd60);
    idleCycle();

    // clear after two of three beats
    $display("[TB] clear");
    applyStimulus(1'b0, 1'b1, 3, 5, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 6, 1'b1);
    applyStimulus(1'b1, 1'b1, 3, 6, 1'b1);
    checkOutput("clear_in_ready", 24'(bus_if.in_ready), 24'h0);
    checkOutput("clear_out_valid", 24'(bus_if.out_valid), 24'h0);
    checkOutput("clear_busy", 24'(busy), 24'h0);
    applyStimulus(1'b0, 1'b1, 1, -1, 1'b1);
    checkOutput("after_clear_data", bus_if.out_data, RELU_ON ? 24'h000000 : 24'hFFFFFF);
    idleCycle();

    // len=0 and len=1 single beats back to back
    $display("[TB] single beats");
    applyStimulus(1'b0, 1'b1, 0, 42, 1'b1);
    checkOutput("len0_data", bus_if.out_data, 24'd42);
    applyStimulus(1'b0, 1'b1, 1, 42, 1'b1);
    checkOutput("len1_valid", 24'(bus_if.out_valid), 24'h1);
    checkOutput("len1_data", bus_if.out_data, 24'd42);
    applyStimulus(1'b0, 1'b1, 1, -5, 1'b1);
    applyStimulus(1'b0, 1'b1, 0, 17, 1'b1);
    checkOutput("len0_second_data", bus_if.out_data, 24'd17);
    idleCycle();

    // Asynchronous reset in the middle of a group
    $display("[TB] reset mid-accumulation");
    applyStimulus(1'b0, 1'b1, 5, 1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5, 2, 1'b1);
    bus_if.in_valid = 1'b0;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_in_ready", 24'(bus_if.in_ready), 24'h1);
    checkOutput("midreset_out_valid", 24'(bus_if.out_valid), 24'h0);
    checkOutput("midreset_out_data", bus_if.out_data, 24'h0);
    checkOutput("midreset_busy", 24'(busy), 24'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1, 5, 1'b1);
    checkOutput("post_reset_data", bus_if.out_data, 24'd5);
    idleCycle();
    idleCycle();

    checks_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
